// File: rtl/fwd_sel_ctrl_pkg.sv
// Shared forwarding definitions: operand-mux select encoding, default register-address width
// and the youngest-stage-wins priority helper.
package fwd_sel_ctrl_pkg;

  localparam int unsigned FWD_REG_W_DEF = 3;

  localparam logic [1:0] FWD_SEL_RF  = 2'b00;
  localparam logic [1:0] FWD_SEL_EX  = 2'b01;
  localparam logic [1:0] FWD_SEL_MEM = 2'b10;
  localparam logic [1:0] FWD_SEL_WB  = 2'b11;

  // Youngest producer wins: EX over MEM over WB.
  function automatic logic [1:0] fwd_sel_prio(input logic ex_hit, input logic mem_hit,
                                              input logic wb_hit);
    if (ex_hit)       return FWD_SEL_EX;
    else if (mem_hit) return FWD_SEL_MEM;
    else if (wb_hit)  return FWD_SEL_WB;
    else              return FWD_SEL_RF;
  endfunction

endpackage

// File: rtl/fwd_sel_ctrl_match.sv
// Per-operand forwarding match: compares one source register against the EX/MEM/WB
// tracker entries and returns the mux select plus an EX-load hit. Honours FWD_ZERO_REG_EN.
module fwd_match
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = FWD_REG_W_DEF
) (
  input  logic             iss_vld,
  input  logic             use_x,
  input  logic [REG_W-1:0] src,
  input  logic             ex_v,
  input  logic             ex_wr,
  input  logic             ex_ld,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_v,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             wb_v,
  input  logic             wb_wr,
  input  logic [REG_W-1:0] wb_dst,
  output logic [1:0]       sel,
  output logic             ld_hit
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

`ifdef FWD_ZERO_REG_EN
  // r0 always reads as zero, so it never needs a forwarded value.
  assign src_live = iss_vld & use_x & (src != '0);
`else
  assign src_live = iss_vld & use_x;
`endif

  assign ex_hit  = src_live & ex_v  & ex_wr  & (ex_dst  == src);
  assign mem_hit = src_live & mem_v & mem_wr & (mem_dst == src);
  assign wb_hit  = src_live & wb_v  & wb_wr  & (wb_dst  == src);

  assign sel    = fwd_sel_prio(ex_hit, mem_hit, wb_hit);
  assign ld_hit = ex_hit & ex_ld;

endmodule

// File: rtl/fwd_sel_ctrl.sv
// Operand-forwarding controller: tracks in-flight destinations through EX/MEM/WB and drives
// the ALU operand mux selects and the load-use stall. Optional macro: FWD_ZERO_REG_EN.
module fwd_sel_ctrl
  import fwd_sel_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = FWD_REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_vld,
  input  logic             iss_wr,
  input  logic             iss_ld,
  input  logic [REG_W-1:0] iss_dst,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  input  logic             use_a,
  input  logic             use_b,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             ld_stall
);

  typedef struct packed {
    logic             v;
    logic             wr;
    logic             ld;
    logic [REG_W-1:0] dst;
  } ex_ent_t;

  // The load flag only matters while the producer sits in EX; MEM/WB results are ready.
  typedef struct packed {
    logic             v;
    logic             wr;
    logic [REG_W-1:0] dst;
  } ret_ent_t;

  ex_ent_t  ex_q, ex_d;
  ret_ent_t mem_q, mem_d;
  ret_ent_t wb_q, wb_d;

  logic iss_wr_eff;
  logic ld_hit_a;
  logic ld_hit_b;

`ifdef FWD_ZERO_REG_EN
  assign iss_wr_eff = iss_wr & (iss_dst != '0);
`else
  assign iss_wr_eff = iss_wr;
`endif

  fwd_match #(
    .REG_W (REG_W)
  ) u_match_a (
    .iss_vld (iss_vld),
    .use_x   (use_a),
    .src     (src_a),
    .ex_v    (ex_q.v),
    .ex_wr   (ex_q.wr),
    .ex_ld   (ex_q.ld),
    .ex_dst  (ex_q.dst),
    .mem_v   (mem_q.v),
    .mem_wr  (mem_q.wr),
    .mem_dst (mem_q.dst),
    .wb_v    (wb_q.v),
    .wb_wr   (wb_q.wr),
    .wb_dst  (wb_q.dst),
    .sel     (sel_a),
    .ld_hit  (ld_hit_a)
  );

  fwd_match #(
    .REG_W (REG_W)
  ) u_match_b (
    .iss_vld (iss_vld),
    .use_x   (use_b),
    .src     (src_b),
    .ex_v    (ex_q.v),
    .ex_wr   (ex_q.wr),
    .ex_ld   (ex_q.ld),
    .ex_dst  (ex_q.dst),
    .mem_v   (mem_q.v),
    .mem_wr  (mem_q.wr),
    .mem_dst (mem_q.dst),
    .wb_v    (wb_q.v),
    .wb_wr   (wb_q.wr),
    .wb_dst  (wb_q.dst),
    .sel     (sel_b),
    .ld_hit  (ld_hit_b)
  );

  assign ld_stall = ld_hit_a | ld_hit_b;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = '{v: ex_q.v, wr: ex_q.wr, dst: ex_q.dst};
      if (flush || ld_stall || !iss_vld) begin
        ex_d = '0;
      end else begin
        ex_d = '{v: 1'b1, wr: iss_wr_eff, ld: iss_ld, dst: iss_dst};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Scoreboard bench for fwd_sel_ctrl: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the live outputs.
module tb_fwd_sel_ctrl;

  localparam int unsigned RW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iss_vld, iss_wr, iss_ld;
  logic [RW-1:0] iss_dst, src_a, src_b;
  logic          use_a, use_b, hold, flush;
  logic [1:0]    sel_a, sel_b;
  logic          ld_stall;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       st;
    logic       chk_sel;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  logic probe = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fwd_sel_ctrl #(
    .REG_W (RW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_vld  (iss_vld),
    .iss_wr   (iss_wr),
    .iss_ld   (iss_ld),
    .iss_dst  (iss_dst),
    .src_a    (src_a),
    .src_b    (src_b),
    .use_a    (use_a),
    .use_b    (use_b),
    .hold     (hold),
    .flush    (flush),
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .ld_stall (ld_stall)
  );

  // Monitor: outputs are combinational, so sample mid-cycle whenever the driver probes.
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard-empty: got outputs with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (ld_stall !== e.st) begin
          fails++;
          $display("FAIL %s ld_stall: got %b want %b", e.name, ld_stall, e.st);
        end
        if (e.chk_sel) begin
          tests++;
          if (sel_a !== e.a) begin
            fails++;
            $display("FAIL %s sel_a: got %b want %b", e.name, sel_a, e.a);
          end
          tests++;
          if (sel_b !== e.b) begin
            fails++;
            $display("FAIL %s sel_b: got %b want %b", e.name, sel_b, e.b);
          end
        end else begin
          tests++;
          if ($isunknown({sel_a, sel_b})) begin
            fails++;
            $display("FAIL %s sel-legal: got %b/%b want 2-bit encodings", e.name, sel_a, sel_b);
          end
        end
      end
    end
  end

  // One cycle: drive inputs, queue the expectation, let the monitor check, then advance.
  task automatic cyc(input logic v, input logic wr, input logic ld, input logic [RW-1:0] dst,
                     input logic [RW-1:0] sa, input logic [RW-1:0] sb, input logic ua,
                     input logic ub, input logic hd, input logic fl, input logic [1:0] ea,
                     input logic [1:0] eb, input logic est, input logic chk, input string nm);
    exp_t e;
    iss_vld = v;  iss_wr = wr;  iss_ld = ld;  iss_dst = dst;
    src_a   = sa; src_b  = sb;  use_a  = ua;  use_b   = ub;
    hold    = hd; flush  = fl;
    e.a = ea; e.b = eb; e.st = est; e.chk_sel = chk; e.name = nm;
    exp_q.push_back(e);
    probe = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) idle("drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] zexp;
    rst_n = 1'b0;
    iss_vld = 0; iss_wr = 0; iss_ld = 0; iss_dst = 0;
    src_a = 0; src_b = 0; use_a = 0; use_b = 0; hold = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset asserted: consumer of r0 with everything in use still sees regfile.
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, "in-reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle("reset-idle");

    // Back-to-back ALU forwarding from r3 as it walks EX -> MEM -> WB -> retired.
    cyc(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "b2b-prod");
    cyc(1, 0, 0, 0, 3, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0, 1, "b2b-ex");
    cyc(1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 2'b00, 2'b10, 0, 1, "b2b-mem");
    cyc(1, 0, 0, 0, 3, 0, 1, 0, 0, 0, 2'b11, 2'b00, 0, 1, "b2b-wb");
    cyc(1, 0, 0, 0, 3, 3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, "b2b-retired");
    drain();

    // Priority: two producers of r5, youngest wins.
    cyc(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "prio-p1");
    cyc(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "prio-p2");
    cyc(1, 0, 0, 0, 5, 5, 1, 1, 0, 0, 2'b01, 2'b01, 0, 1, "prio-young");
    cyc(1, 0, 0, 0, 5, 5, 1, 0, 0, 0, 2'b10, 2'b00, 0, 1, "prio-mem-use0");
    cyc(0, 0, 0, 0, 5, 5, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, "prio-vld0");
    drain();

    // Load-use on operand A: one stall cycle, bubble, then forward from MEM.
    cyc(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "ld-prod");
    cyc(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, "ld-stall");
    cyc(1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 2'b10, 2'b00, 0, 1, "ld-after");
    drain();

    // Load-use on operand B, and use_b=0 suppresses it.
    cyc(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "ldb-prod");
    cyc(1, 0, 0, 0, 0, 6, 0, 0, 1, 0, 2'b00, 2'b00, 0, 1, "ldb-use0-hold");
    cyc(1, 0, 0, 0, 0, 6, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0, "ldb-stall");
    drain();

    // hold keeps r4 in EX for three cycles, then advances.
    cyc(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "hold-prod");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 4, 0, 1, 0, 1, 0, 2'b01, 2'b00, 0, 1, "hold-ex");
    cyc(1, 0, 0, 0, 4, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0, 1, "hold-release");
    cyc(1, 0, 0, 0, 4, 0, 1, 0, 0, 0, 2'b10, 2'b00, 0, 1, "hold-mem");
    drain();

    // flush kills the instruction entering EX.
    cyc(1, 1, 0, 7, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, "flush-prod");
    cyc(1, 0, 0, 0, 7, 7, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, "flush-absent");
    drain();

    // hold overrides flush.
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "hf-prod");
    cyc(1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 2'b01, 2'b00, 0, 1, "hf-held");
    cyc(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0, 1, "hf-kept");
    drain();

    // Register 0 producer.
`ifdef FWD_ZERO_REG_EN
    zexp = 2'b00;
`else
    zexp = 2'b01;
`endif
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "zero-prod");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, zexp, 2'b00, 0, 1, "zero-cons");
    drain();

    // Asynchronous reset mid-flight discards r3.
    cyc(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "mrst-prod");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 3, 3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, "mrst-gone");

    probe = 1'b0;
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard-drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Operand-forwarding controller in the proc datapath.
- Generates the 2-bit select for each ALU-operand 4:1 mux: regfile, EX result, MEM result or WB result.
- Tracks in-flight destination registers through a 3-entry shadow pipeline (EX/MEM/WB).
- Raises a load-use stall when a consumer needs a load result that is not yet available.

Parameters:
- REG_W, 3, register-address width (2**REG_W architectural registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iss_vld  input  1  decode stage presents a valid instruction this cycle.
- iss_wr  input  1  issuing instruction writes a destination register.
- iss_ld  input  1  issuing instruction is a load (result available at end of MEM).
- iss_dst  input  REG_W  issuing instruction destination register.
- src_a  input  REG_W  operand-A source register of the issuing instruction.
- src_b  input  REG_W  operand-B source register of the issuing instruction.
- use_a  input  1  issuing instruction reads src_a.
- use_b  input  1  issuing instruction reads src_b.
- hold  input  1  global pipeline freeze (memory wait); no tracker advance.
- flush  input  1  branch taken; kill the instruction entering EX.
- sel_a  output  2  operand-A mux select: 00 regfile, 01 EX, 10 MEM, 11 WB.
- sel_b  output  2  operand-B mux select, same encoding.
- ld_stall  output  1  load-use hazard; decode must hold its instruction.

Behaviour:
- State: three entries EX, MEM, WB, each {v, wr, ld, dst}.
- Reset (async, rst_n=0): all v=0. Outputs then read sel_a=sel_b=00 and ld_stall=0 combinationally.
- Selects are combinational from current state plus src/use inputs; zero latency.
- Operand match rule: stage S matches X when S.v & S.wr & S.dst==src_X & use_X.
- Priority for the select: youngest stage wins. EX match gives 01; else MEM match gives 10; else WB match gives 11; else 00.
- use_X=0 or iss_vld=0 forces sel_X=00.
- ld_stall = iss_vld & EX.v & EX.wr & EX.ld & ((use_a & EX.dst==src_a) | (use_b & EX.dst==src_b)).
- When ld_stall=1, sel outputs are don't-care; the bench checks only that they hold a legal encoding.
- Clock edge with hold=1: all entries keep their value. hold overrides flush and ld_stall.
- Clock edge with hold=0: WB<=MEM and MEM<=EX. EX is loaded as follows:
  - if flush=1 or ld_stall=1 or iss_vld=0, EX<=bubble (v=0);
  - otherwise EX<={1, iss_wr, iss_ld, iss_dst}.
- flush and ld_stall together: bubble is inserted (same outcome as either alone).
- A WB entry retires on the next advance. Regfile write-through in the same cycle is the regfile's concern; a WB match still selects 11.
- Reset mid-operation: all in-flight entries are discarded immediately. No residual forwarding after rst_n deasserts.

Optional Feature:
- Macro FWD_ZERO_REG_EN.
- Defined: register 0 is hard-wired zero. Any src_X==0 forces sel_X=00 and never contributes to ld_stall. Entries with dst==0 are loaded with wr=0.
- Undefined: register 0 is treated like any other register.

Decomposition:
- Shared proc header (`include) holds the select-encoding constants: FWD_SEL_RF=2'b00, FWD_SEL_EX=2'b01, FWD_SEL_MEM=2'b10, FWD_SEL_WB=2'b11. It also holds the default REG_W.
- One natural sub-module: fwd_match (combinational, instantiated once per operand). It takes the three entries plus src and use, and returns the 2-bit select and a load-hit bit. Tracker registers and stall logic stay in the top module.

Test Plan:
- Reset/idle: rst_n low then high, no issue -> sel_a=sel_b=00, ld_stall=0 for 5 cycles.
- Back-to-back ALU: issue wr dst=3, then an instruction with src_a=3 -> sel_a=01. Next cycle, an instruction with src_b=3 -> sel_b=10. Third cycle, src_a=3 -> sel_a=11. Fourth cycle -> 00.
- Priority: issue dst=5 twice in consecutive cycles, then a consumer of r5 -> sel=01 (youngest), not 10.
- Load-use: issue ld dst=2, then a consumer with src_a=2 -> ld_stall=1 for exactly one cycle with a bubble inserted. The held consumer then sees sel_a=10.
- hold/flush: with dst=4 in EX, hold=1 for 3 cycles -> sel stays 01 for a src=4 consumer. flush=1 on an advance -> the next cycle shows the flushed dst is absent.
- FWD_ZERO_REG_EN: issue wr dst=0, then a consumer with src_a=0 -> sel_a=00 with the macro defined, and 01 with it undefined.
